// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and default geometry for the set-associative cache
package cache_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_SETS  = 4;
  localparam int DEFAULT_WAYS  = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_MISS  = 2'd1,
    WRITE_THRU = 2'd2
  } cache_state_e;

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - picks the refill way: lowest invalid way, else the round-robin pointer
module cache_victim_sel #(
  parameter int WAYS  = 4,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] ptr_i,
  output logic [WAY_W-1:0] way_o
);

  logic found;

  always_comb begin
    way_o = ptr_i;
    found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        way_o = WAY_W'(w);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-through, no-write-allocate set-associative cache
// with combinational hit path and round-robin replacement.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SETS  = DEFAULT_SETS,
  parameter int WAYS  = DEFAULT_WAYS
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cache_enable_i,
  input  logic             write_enable_i,
  input  logic             byte_op_i,
  input  logic [WIDTH-1:0] address_i,
  input  logic [WIDTH-1:0] write_data_i,
  output logic [WIDTH-1:0] read_data_o,
  output logic             stall_o,
  output logic             mem_req_o,
  input  logic             mem_ack_i,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic [WIDTH-1:0] mem_incoming_data_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = WIDTH - 2 - IDX_W;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WIDTH-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0] rr_q    [SETS];

  cache_state_e state_q, state_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [1:0]       offset;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim;
  logic [WIDTH-1:0] hit_data;
  logic             fill;
  logic             update;

  assign idx    = address_i[2 +: IDX_W];
  assign tag    = address_i[WIDTH-1 -: TAG_W];
  assign offset = address_i[1:0];

  assign mem_address_o    = address_i;
  assign mem_write_data_o = write_data_i;

  function automatic logic [WIDTH-1:0] load_fmt(input logic [WIDTH-1:0] word,
                                                input logic             is_byte,
                                                input logic [1:0]       lane);
    logic [7:0] b;
    b = word[{lane, 3'b000} +: 8];
    return is_byte ? {{(WIDTH-8){1'b0}}, b} : word;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_data = data_q[idx][hit_way];

  cache_victim_sel #(
    .WAYS (WAYS),
    .WAY_W(WAY_W)
  ) u_victim_sel (
    .valid_i(valid_q[idx]),
    .ptr_i  (rr_q[idx]),
    .way_o  (victim)
  );

  always_comb begin
    state_d            = state_q;
    stall_o            = 1'b0;
    mem_req_o          = 1'b0;
    mem_write_enable_o = 1'b0;
    mem_byte_op_o      = 1'b0;
    read_data_o        = '0;
    fill               = 1'b0;
    update             = 1'b0;
    case (state_q)
      IDLE: begin
        if (cache_enable_i) begin
          if (write_enable_i) begin
            stall_o = 1'b1;
            state_d = WRITE_THRU;
          end else if (hit) begin
            read_data_o = load_fmt(hit_data, byte_op_i, offset);
          end else begin
            stall_o = 1'b1;
            state_d = READ_MISS;
          end
        end
      end
      READ_MISS: begin
        mem_req_o = 1'b1;
        stall_o   = !mem_ack_i;
        if (mem_ack_i) begin
          read_data_o = load_fmt(mem_incoming_data_i, byte_op_i, offset);
          fill        = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE_THRU: begin
        mem_req_o          = 1'b1;
        mem_write_enable_o = 1'b1;
        mem_byte_op_o      = byte_op_i;
        stall_o            = !mem_ack_i;
        if (mem_ack_i) begin
          // Store misses fall through here without touching the arrays.
          update  = hit;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx][victim] <= 1'b1;
        rr_q[idx]            <= rr_q[idx] + WAY_W'(1);
      end
    end
  end

  // Tag/data need no reset; the write strobes are suppressed while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill) begin
      tag_q[idx][victim]  <= tag;
      data_q[idx][victim] <= mem_incoming_data_i;
    end
    if (!rst_i && update) begin
      if (byte_op_i) begin
        data_q[idx][hit_way][{offset, 3'b000} +: 8] <= write_data_i[7:0];
      end else begin
        data_q[idx][hit_way] <= write_data_i;
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - scoreboard bench for set_assoc_cache: directed accesses,
// expected completions queued by the driver and checked by a negedge monitor.
module tb_set_assoc_cache;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cache_enable_i;
  logic        write_enable_i;
  logic        byte_op_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [31:0] mem_address_o;
  logic [31:0] mem_write_data_o;
  logic        mem_write_enable_o;
  logic        mem_byte_op_o;
  logic [31:0] mem_incoming_data_i;

  typedef struct {
    logic [31:0] data;
    int          stalls;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;

  always #5 clk_i = ~clk_i;

  set_assoc_cache #(.WIDTH(32), .SETS(4), .WAYS(4)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .cache_enable_i     (cache_enable_i),
    .write_enable_i     (write_enable_i),
    .byte_op_i          (byte_op_i),
    .address_i          (address_i),
    .write_data_i       (write_data_i),
    .read_data_o        (read_data_o),
    .stall_o            (stall_o),
    .mem_req_o          (mem_req_o),
    .mem_ack_i          (mem_ack_i),
    .mem_address_o      (mem_address_o),
    .mem_write_data_o   (mem_write_data_o),
    .mem_write_enable_o (mem_write_enable_o),
    .mem_byte_op_o      (mem_byte_op_o),
    .mem_incoming_data_i(mem_incoming_data_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle a request is presented, count stalls; on completion pop and compare.
  always @(negedge clk_i) begin
    if (rst_i) begin
      stall_cnt = 0;
    end else if (cache_enable_i) begin
      if (stall_o) begin
        stall_cnt++;
        check("read_data_during_stall", read_data_o, 32'h0);
      end else if (q.size() == 0) begin
        check("unexpected_completion", 32'h1, 32'h0);
        stall_cnt = 0;
      end else begin
        exp_t e;
        e = q.pop_front();
        check("read_data", read_data_o, e.data);
        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        stall_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cache_enable_i = 1'b0;
    mem_ack_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_stall", {31'b0, stall_o}, 32'h0);
    check("reset_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("reset_read_data", read_data_o, 32'h0);
  endtask

  task automatic access(input logic we, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] mdata,
                        input int ack_after, input logic [31:0] exp_data,
                        input int exp_stalls, input logic exp_req);
    int   cnt;
    logic done;
    logic saw_req;
    exp_t e;
    @(posedge clk_i); #1;
    cache_enable_i      = 1'b1;
    write_enable_i      = we;
    byte_op_i           = bt;
    address_i           = addr;
    write_data_i        = wdata;
    mem_incoming_data_i = mdata;
    mem_ack_i           = 1'b0;
    e.data   = exp_data;
    e.stalls = exp_stalls;
    q.push_back(e);
    cnt = 0;
    done = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        saw_req = 1'b1;
        check("mem_write_enable", {31'b0, mem_write_enable_o}, {31'b0, we});
        check("mem_byte_op", {31'b0, mem_byte_op_o}, {31'b0, we & bt});
        check("mem_address", mem_address_o, addr);
        if (we) check("mem_write_data", mem_write_data_o, wdata);
      end
      if (!stall_o) done = 1'b1;
      @(posedge clk_i); #1;
      if (!done && mem_req_o) begin
        cnt++;
        mem_ack_i = (cnt == ack_after);
      end
    end
    if (!done) begin
      check("access_timeout", 32'h1, 32'h0);
      q.delete();
    end
    cache_enable_i = 1'b0;
    mem_ack_i      = 1'b0;
    check("mem_req_seen", {31'b0, saw_req}, {31'b0, exp_req});
  endtask

  initial begin
    rst_i = 1'b1;
    cache_enable_i = 1'b0;
    write_enable_i = 1'b0;
    byte_op_i = 1'b0;
    address_i = '0;
    write_data_i = '0;
    mem_ack_i = 1'b0;
    mem_incoming_data_i = '0;

    do_reset();

    // load miss/hit, byte load hit, byte store hit, word readback
    access(0, 0, 32'h10, 32'h0,  32'hDEADBEEF, 2, 32'hDEADBEEF, 2, 1);
    access(0, 0, 32'h10, 32'h0,  32'h0,        1, 32'hDEADBEEF, 0, 0);
    access(0, 1, 32'h12, 32'h0,  32'h0,        1, 32'h000000AD, 0, 0);
    access(1, 1, 32'h11, 32'h55, 32'h0,        3, 32'h0,        3, 1);
    access(0, 0, 32'h10, 32'h0,  32'h0,        1, 32'hDEAD55EF, 0, 0);

    // store miss does not allocate; byte load miss selects lane 3 of the fetched word
    access(1, 0, 32'h24, 32'h12345678, 32'h0,        1, 32'h0,        1, 1);
    access(0, 0, 32'h24, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 1);
    access(0, 0, 32'h24, 32'h0,        32'h0,        1, 32'hCAFEF00D, 0, 0);
    access(0, 1, 32'h2B, 32'h0,        32'h11223344, 2, 32'h00000011, 2, 1);

    // reset while a read miss is outstanding
    @(posedge clk_i); #1;
    cache_enable_i = 1'b1;
    write_enable_i = 1'b0;
    byte_op_i = 1'b0;
    address_i = 32'h30;
    @(negedge clk_i);
    check("abort_idle_stall", {31'b0, stall_o}, 32'h1);
    @(posedge clk_i); #1;
    check("abort_mem_req", {31'b0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    cache_enable_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_abort_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("post_abort_stall", {31'b0, stall_o}, 32'h0);
    access(0, 0, 32'h30, 32'h0, 32'h0BADCAFE, 1, 32'h0BADCAFE, 1, 1);

    // fill set 0 then force round-robin eviction of way 0
    do_reset();
    access(0, 0, 32'h000, 32'h0, 32'hA0A0A0A0, 1, 32'hA0A0A0A0, 1, 1);
    access(0, 0, 32'h040, 32'h0, 32'hA1A1A1A1, 1, 32'hA1A1A1A1, 1, 1);
    access(0, 0, 32'h080, 32'h0, 32'hA2A2A2A2, 1, 32'hA2A2A2A2, 1, 1);
    access(0, 0, 32'h0C0, 32'h0, 32'hA3A3A3A3, 1, 32'hA3A3A3A3, 1, 1);
    access(0, 0, 32'h100, 32'h0, 32'hA4A4A4A4, 1, 32'hA4A4A4A4, 1, 1);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    check("idle_ack_ignored_stall", {31'b0, stall_o}, 32'h0);
    check("idle_ack_ignored_req", {31'b0, mem_req_o}, 32'h0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    access(0, 0, 32'h040, 32'h0, 32'h0,        1, 32'hA1A1A1A1, 0, 0);
    access(0, 0, 32'h100, 32'h0, 32'h0,        1, 32'hA4A4A4A4, 0, 0);
    access(0, 0, 32'h000, 32'h0, 32'hB0B0B0B0, 2, 32'hB0B0B0B0, 2, 1);

    repeat (3) @(posedge clk_i);
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: WIDTH, 32, data/address width in bits.
REQ-003 Parameter: SETS, 4, number of sets, power of two, at least 2.
REQ-004 Parameter: WAYS, 4, ways per set, power of two, at least 2.
REQ-005 Ports SHALL be exactly:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cache_enable_i  in  1  request valid.
- write_enable_i  in  1  1 = store, 0 = load.
- byte_op_i  in  1  1 = byte access, 0 = word access.
- address_i  in  WIDTH  byte address.
- write_data_i  in  WIDTH  store data; byte stores use [7:0].
- read_data_o  out  WIDTH  load result.
- stall_o  out  1  request not yet complete.
- mem_req_o  out  1  memory request valid.
- mem_ack_i  in  1  memory completes the request this cycle.
- mem_address_o  out  WIDTH  memory address.
- mem_write_data_o  out  WIDTH  memory store data.
- mem_write_enable_o  out  1  memory store.
- mem_byte_op_o  out  1  memory byte store.
- mem_incoming_data_i  in  WIDTH  memory word read data.

Function
REQ-006 Address split: byte offset = [1:0]; index = [2 +: log2(SETS)]; tag = remaining upper bits.
REQ-007 Hit detection SHALL be combinational on clk_i posedge state: hit = a valid way in the indexed set has a matching tag.
REQ-008 FSM states SHALL be IDLE, READ_MISS and WRITE_THRU.
REQ-009 IDLE load hit: stall_o = 0, read_data_o = cached data the same cycle, no memory request.
REQ-010 IDLE load miss: stall_o = 1, next state READ_MISS.
REQ-011 IDLE store (hit or miss): stall_o = 1, next state WRITE_THRU.
REQ-012 READ_MISS:
- mem_req_o = 1, mem_write_enable_o = 0, mem_byte_op_o = 0, whole word fetched.
- Held until mem_ack_i.
- On the ack cycle: stall_o = 0, read_data_o = mem data (byte-selected), victim way filled with valid, tag and data at the next edge, return to IDLE.
REQ-013 WRITE_THRU:
- mem_req_o = 1, mem_write_enable_o = 1, mem_byte_op_o = byte_op_i, mem_write_data_o = write_data_i.
- On the ack cycle: stall_o = 0; on a hit the matching way's byte lane or word is updated; return to IDLE.
REQ-014 Store miss SHALL NOT allocate (write-no-allocate).
REQ-015 Byte loads SHALL zero-extend byte [8*offset +: 8] of the word.
REQ-016 Victim SHALL be the lowest-index invalid way; otherwise the set's round-robin pointer, which increments modulo WAYS on each refill.
REQ-017 mem_address_o SHALL equal address_i.
REQ-018 The requester SHALL hold its inputs stable while stall_o = 1; the block is not required to tolerate input changes then.
REQ-019 cache_enable_i = 0 in IDLE: stall_o = 0, mem_req_o = 0, read_data_o = 0, no state change.
REQ-020 read_data_o SHALL be 0 except in a cycle completing a load.
REQ-021 mem_ack_i outside READ_MISS/WRITE_THRU SHALL be ignored.

Reset
REQ-022 Reset SHALL force IDLE, clear all valid bits, zero all round-robin pointers, and drive stall_o, mem_req_o and read_data_o to 0 the following cycle.
REQ-023 Reset in READ_MISS or WRITE_THRU SHALL abandon the transaction with no array update.

Structure
REQ-024 Package cache_pkg SHALL hold the FSM state enum and the default WIDTH/SETS/WAYS constants.
REQ-025 The victim selector SHALL be sub-module cache_victim_sel: per-set valid vector and pointer in, way index out.

Verification
REQ-026 Read 0x10 after reset, ack 2 cycles later with 0xDEADBEEF: stall_o high 2 cycles, read_data_o 0xDEADBEEF on the ack cycle; re-read 0x10 gives stall_o 0 and mem_req_o 0.
REQ-027 Byte load 0x12 with 0x10 cached as 0xDEADBEEF: read_data_o 0x000000AD, no memory request.
REQ-028 Byte store 0x55 to 0x11 (hit): mem_byte_op_o 1, mem_write_data_o 0x55, held until ack; later word read 0x10 returns 0xDEAD55EF from cache.
REQ-029 Read misses 0x00, 0x40, 0x80, 0xC0, 0x100 (set 0): the fifth evicts 0x00; read 0x00 misses and read 0x40 hits.
REQ-030 Store miss to 0x24 then load 0x24: the load misses and mem_req_o is asserted.
REQ-031 rst_i asserted in READ_MISS: mem_req_o 0 next cycle, and a re-read of the same address misses.
